// File: rtl/mtl2_led_pkg.sv
// Shared types and constants for the LED PIO write arbiter.
package mtl2_led_pkg;

   localparam int unsigned DEFAULT_DATA_W  = 8;
   localparam int unsigned DEFAULT_TIMEOUT = 255;
   localparam int unsigned CNT_W           = 16;
   localparam int unsigned AVM_ADDR_W      = 2;
   localparam int unsigned AVM_DATA_W      = 32;

   localparam logic [AVM_ADDR_W-1:0] LED_PIO_ADDR = AVM_ADDR_W'(0);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

endpackage

// File: rtl/mtl2_led_rr_arb.sv
// Two-input round-robin grant; the most recent winner loses a tie.
module mtl2_led_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   logic r_last_b;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = r_last_b ? 2'b01 : 2'b10;
      end
   end

   // Reset to "B won last" so A takes the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_b <= 1'b1;
      end else if (update && (grant != 2'b00)) begin
         r_last_b <= grant[1];
      end
   end

endmodule

// File: rtl/mtl2_led_arbiter.sv
// Arbitrates two LED pattern requesters onto an Avalon-MM write master to the LED PIO.
module mtl2_led_arbiter
   import mtl2_led_pkg::*;
#(
   parameter int unsigned DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_valid,
   input  logic [DATA_W-1:0]     a_pattern,
   input  logic                  b_valid,
   input  logic [DATA_W-1:0]     b_pattern,
   output logic                  a_ready,
   output logic                  b_ready,
   output logic                  err,
   output logic [AVM_ADDR_W-1:0] avm_address,
   output logic                  avm_chipselect,
   output logic                  avm_write_n,
   output logic [AVM_DATA_W-1:0] avm_writedata,
   input  logic                  avm_waitrequest,
   output logic [DATA_W-1:0]     leds_shadow
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_sel_b;
   logic [DATA_W-1:0] r_pattern;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [DATA_W-1:0] r_leds;
   logic [1:0]        w_grant;
   logic              w_done;
   logic              w_abort;

   mtl2_led_rr_arb u_rr_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({b_valid, a_valid}),
      .update (r_state == ST_IDLE),
      .grant  (w_grant)
   );

   // State register plus the transfer datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_sel_b    <= 1'b0;
         r_pattern  <= '0;
         r_wait_cnt <= '0;
         r_leds     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && (w_grant != 2'b00)) begin
            r_sel_b    <= w_grant[1];
            r_pattern  <= w_grant[1] ? b_pattern : a_pattern;
            r_wait_cnt <= '0;
         end else if ((r_state == ST_WRITE) && avm_waitrequest) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         end
         if (w_done) begin
            r_leds <= r_pattern;
         end
      end
   end

   // Next state: a stalled write aborts on its TIMEOUT-th waitrequest cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_grant != 2'b00) begin
               w_state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (!avm_waitrequest) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Bus decode from state; completion pulses suppressed while reset drops the transfer.
   always_comb begin
      avm_address    = LED_PIO_ADDR;
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      avm_writedata  = '0;
      a_ready        = 1'b0;
      b_ready        = 1'b0;
      err            = 1'b0;
      if (r_state == ST_WRITE) begin
         avm_chipselect = 1'b1;
         avm_write_n    = 1'b0;
         avm_writedata  = AVM_DATA_W'(r_pattern);
      end
      if (!reset && (w_done || w_abort)) begin
         a_ready = !r_sel_b;
         b_ready = r_sel_b;
         err     = w_abort;
      end
   end

   assign leds_shadow = r_leds;

endmodule

// File: tb/tb_mtl2_led_arbiter.sv
// Directed and randomized checks of mtl2_led_arbiter against a transaction-level model.
module tb_mtl2_led_arbiter;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_valid, b_valid;
   logic [7:0]  a_pattern, b_pattern;
   logic        a_ready, b_ready, err;
   logic [1:0]  avm_address;
   logic        avm_chipselect, avm_write_n;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [7:0]  leds_shadow;

   int total = 0;
   int bad   = 0;

   // Model: one outstanding transfer with owner, data and stall count.
   bit       m_busy;
   int       m_owner;
   logic [7:0] m_data;
   int       m_stalls;
   int       m_last;
   logic [7:0] m_shadow;
   bit       m_ar, m_br;

   logic [7:0] wq[$];
   int         rq[$];
   int         cs_cnt, err_cnt;

   mtl2_led_arbiter #(.DATA_W(8), .TIMEOUT(TO)) dut (
      .clk             (clk),
      .reset           (reset),
      .a_valid         (a_valid),
      .a_pattern       (a_pattern),
      .b_valid         (b_valid),
      .b_pattern       (b_pattern),
      .a_ready         (a_ready),
      .b_ready         (b_ready),
      .err             (err),
      .avm_address     (avm_address),
      .avm_chipselect  (avm_chipselect),
      .avm_write_n     (avm_write_n),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .leds_shadow     (leds_shadow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Called at posedge+1 with inputs driven; checks at negedge, then advances the model.
   task automatic step();
      bit fin, ab;
      #4;
      fin = m_busy && !reset && (!avm_waitrequest || (m_stalls + 1 == int'(TO)));
      ab  = fin && avm_waitrequest;
      chk("chipselect", avm_chipselect, m_busy);
      chk("write_n", avm_write_n, !m_busy);
      chk("address", avm_address, 0);
      chk("writedata", avm_writedata, m_busy ? {24'h0, m_data} : 32'h0);
      chk("a_ready", a_ready, fin && (m_owner == 0));
      chk("b_ready", b_ready, fin && (m_owner == 1));
      chk("err", err, ab);
      chk("leds_shadow", leds_shadow, m_shadow);
      if (avm_chipselect) cs_cnt++;
      if (err) err_cnt++;
      if (avm_chipselect && !avm_waitrequest && !reset) wq.push_back(avm_writedata[7:0]);
      if (a_ready) rq.push_back(0);
      if (b_ready) rq.push_back(1);
      m_ar = fin && (m_owner == 0);
      m_br = fin && (m_owner == 1);
      if (reset) begin
         m_busy = 0; m_shadow = 8'h00; m_last = 1; m_stalls = 0;
      end else if (m_busy) begin
         if (!avm_waitrequest) begin
            m_shadow = m_data; m_busy = 0;
         end else if (ab) begin
            m_busy = 0;
         end else begin
            m_stalls++;
         end
      end else if (a_valid || b_valid) begin
         if (a_valid && b_valid) m_owner = (m_last == 1) ? 0 : 1;
         else                    m_owner = b_valid ? 1 : 0;
         m_last   = m_owner;
         m_data   = (m_owner == 1) ? b_pattern : a_pattern;
         m_busy   = 1;
         m_stalls = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; a_valid = 0; b_valid = 0; avm_waitrequest = 0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; a_valid = 0; b_valid = 0; a_pattern = 0; b_pattern = 0; avm_waitrequest = 0;
      m_busy = 0; m_owner = 0; m_data = 0; m_stalls = 0; m_last = 1; m_shadow = 0;
      cs_cnt = 0; err_cnt = 0;
      @(posedge clk); #1;
      step(); step();
      reset = 1'b0;

      // Single A write with no stall
      wq.delete(); rq.delete();
      a_valid = 1; a_pattern = 8'hA5;
      step(); step();
      a_valid = 0;
      step();
      chk("t028_shadow", leds_shadow, 8'hA5);
      chk("t028_nwrites", wq.size(), 1);
      if (wq.size() > 0) chk("t028_data", wq[0], 8'hA5);

      // Both held from reset: strict alternation A,B,A,B
      reset = 1; a_valid = 1; b_valid = 1; a_pattern = 8'h01; b_pattern = 8'h02;
      step();
      reset = 0;
      wq.delete(); rq.delete();
      for (int i = 0; i < 8; i++) step();
      a_valid = 0; b_valid = 0;
      step();
      chk("t029_nwrites", wq.size(), 4);
      chk("t029_nready", rq.size(), 4);
      for (int i = 0; i < 4 && i < wq.size() && i < rq.size(); i++) begin
         chk("t029_order", wq[i], (i % 2 == 0) ? 8'h01 : 8'h02);
         chk("t029_who", rq[i], i % 2);
      end

      // Three stall cycles: chipselect for four cycles, ready in the fourth
      do_reset();
      rq.delete();
      a_valid = 1; a_pattern = 8'h3C;
      step();
      avm_waitrequest = 1; cs_cnt = 0;
      step(); step(); step();
      chk("t030_noready_yet", rq.size(), 0);
      avm_waitrequest = 0;
      step();
      a_valid = 0;
      step();
      chk("t030_cs_cycles", cs_cnt, 4);
      chk("t030_nready", rq.size(), 1);

      // Timeout abort on B after a good A write
      do_reset();
      a_valid = 1; a_pattern = 8'h11;
      step(); step();
      a_valid = 0; b_valid = 1; b_pattern = 8'h77;
      avm_waitrequest = 1; err_cnt = 0; rq.delete();
      step();
      for (int i = 0; i < int'(TO); i++) step();
      b_valid = 0;
      chk("t031_err_count", err_cnt, 1);
      chk("t031_b_ready", rq.size() == 1 && rq[0] == 1, 1);
      chk("t031_idle", avm_chipselect, 0);
      chk("t031_shadow", leds_shadow, 8'h11);
      avm_waitrequest = 0;
      step();

      // Reset in the second WRITE cycle, A must win first afterwards
      do_reset();
      a_valid = 1; a_pattern = 8'h5A;
      step(); step();
      a_valid = 0; b_valid = 1; b_pattern = 8'h6B; avm_waitrequest = 1;
      rq.delete(); err_cnt = 0;
      step(); step();
      reset = 1;
      step();
      reset = 0; a_valid = 1; avm_waitrequest = 0;
      chk("t032_bus_idle", avm_chipselect, 0);
      chk("t032_shadow", leds_shadow, 8'h00);
      chk("t032_no_pulse", rq.size() + err_cnt, 0);
      step(); step();
      chk("t032_first_a", rq.size() == 1 && rq[0] == 0, 1);
      a_valid = 0; b_valid = 0;
      step();

      // Random traffic with stalls, mid-transfer pattern changes/valid drops, rare resets
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         avm_waitrequest = ($urandom_range(0, 2) == 0);
         if (m_ar || !a_valid) begin
            a_valid = ($urandom_range(0, 2) == 0);
            a_pattern = 8'($urandom);
         end else if (m_busy && m_owner == 0 && $urandom_range(0, 3) == 0) begin
            a_pattern = 8'($urandom);
            if ($urandom_range(0, 1) == 0) a_valid = 0;
         end
         if (m_br || !b_valid) begin
            b_valid = ($urandom_range(0, 2) == 0);
            b_pattern = 8'($urandom);
         end else if (m_busy && m_owner == 1 && $urandom_range(0, 3) == 0) begin
            b_pattern = 8'($urandom);
            if ($urandom_range(0, 1) == 0) b_valid = 0;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
